// File: rtl/hci_core_outstanding_gate_if.sv
// HCI core request/response bundle shared by initiators and targets.
// Request fields travel initiator->target, response fields travel target->initiator.
interface hci_core_intf #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 32,
    parameter int unsigned BW = 8,
    parameter int unsigned UW = 1
) ();

    logic              req;
    logic              gnt;
    logic [AW-1:0]     add;
    logic              wen;
    logic [DW-1:0]     data;
    logic [DW/BW-1:0]  be;
    logic [UW-1:0]     user;
    logic              r_ready;
    logic [DW-1:0]     r_data;
    logic              r_valid;
    logic [UW-1:0]     r_user;
    logic              r_opc;

    modport initiator (
        output req, add, wen, data, be, user, r_ready,
        input  gnt, r_data, r_valid, r_user, r_opc
    );

    modport target (
        input  req, add, wen, data, be, user, r_ready,
        output gnt, r_data, r_valid, r_user, r_opc
    );

endinterface

// File: rtl/hci_core_outstanding_gate.sv
// One-entry request slot that caps granted-but-unanswered transactions ahead of the demux.
// Optional response watchdog is enabled by defining HCI_OUTSTANDING_GATE_TIMEOUT_EN.
package hci_package;
    parameter int unsigned DEFAULT_AW = 32;
    parameter int unsigned DEFAULT_DW = 32;
    parameter int unsigned DEFAULT_UW = 1;
endpackage

module hci_core_outstanding_gate #(
    parameter int unsigned AW              = hci_package::DEFAULT_AW,
    parameter int unsigned DW              = hci_package::DEFAULT_DW,
    parameter int unsigned UW              = hci_package::DEFAULT_UW,
    parameter int unsigned MAX_OUTSTANDING = 1,
    parameter int unsigned TIMEOUT_CYCLES  = 256
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    hci_core_intf.target                         target,
    hci_core_intf.initiator                      initiator,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
    output logic                                 timeout_o
);

    localparam int unsigned CW  = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned BEW = DW / 8;
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);

    if (MAX_OUTSTANDING == 0) begin : g_bad_max
        $error("MAX_OUTSTANDING must be at least 1");
    end
    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    logic            slot_v_q;
    logic [AW-1:0]   slot_add_q;
    logic            slot_wen_q;
    logic [DW-1:0]   slot_data_q;
    logic [BEW-1:0]  slot_be_q;
    logic [UW-1:0]   slot_user_q;

    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic            issue;
    logic            done;
    logic            accept;

    // The slot may refill in the same cycle it drains, giving one request per cycle.
    assign initiator.req  = slot_v_q && (cnt_q < CNT_MAX);
    assign issue          = initiator.req && initiator.gnt;
    assign target.gnt     = !slot_v_q || issue;
    assign accept         = target.req && target.gnt;
    assign done           = initiator.r_valid && initiator.r_ready;

    assign initiator.add  = slot_add_q;
    assign initiator.wen  = slot_wen_q;
    assign initiator.data = slot_data_q;
    assign initiator.be   = slot_be_q;
    assign initiator.user = slot_user_q;

    assign target.r_valid    = initiator.r_valid;
    assign target.r_data     = initiator.r_data;
    assign target.r_user     = initiator.r_user;
    assign target.r_opc      = initiator.r_opc;
    assign initiator.r_ready = target.r_ready;

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slot_v_q    <= 1'b0;
            slot_add_q  <= '0;
            slot_wen_q  <= 1'b0;
            slot_data_q <= '0;
            slot_be_q   <= '0;
            slot_user_q <= '0;
        end else if (accept) begin
            slot_v_q    <= 1'b1;
            slot_add_q  <= target.add;
            slot_wen_q  <= target.wen;
            slot_data_q <= target.data;
            slot_be_q   <= target.be;
            slot_user_q <= target.user;
        end else if (issue) begin
            slot_v_q    <= 1'b0;
        end
    end

    // A response with nothing outstanding belongs to a transaction forgotten by reset.
    always_comb begin
        cnt_d = cnt_q;
        if (issue && !done) begin
            cnt_d = cnt_q + 1'b1;
        end else if (done && !issue && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign outstanding_o = cnt_q;

`ifdef HCI_OUTSTANDING_GATE_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMR_MAX = TW'(TIMEOUT_CYCLES);

    logic [TW-1:0] tmr_q;
    logic          timeout_q;
    logic          tmr_hit;

    assign tmr_hit = (tmr_q == TMR_MAX);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tmr_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            if ((cnt_q == '0) || done) begin
                tmr_q <= '0;
            end else if (!tmr_hit) begin
                tmr_q <= tmr_q + 1'b1;
            end
            if (tmr_hit) begin
                timeout_q <= 1'b1;
            end
        end
    end

    // Flag is visible in the very cycle the timer saturates, then held by timeout_q.
    assign timeout_o = timeout_q || tmr_hit;
`else
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_hci_core_outstanding_gate.sv
// Directed self-checking bench: reset, single read, cap, simultaneous issue/done,
// backpressure, spurious response and watchdog behaviour.
module tb_hci_core_outstanding_gate;

`ifdef HCI_OUTSTANDING_GATE_TIMEOUT_EN
    localparam logic EXP_TMO = 1'b1;
`else
    localparam logic EXP_TMO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       outst_a;
    logic       tmo_a;
    logic [1:0] outst_b;
    logic       tmo_b;
    int         n_cmp  = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    hci_core_intf #(.DW(32), .AW(32), .BW(8), .UW(1)) ta_if ();
    hci_core_intf #(.DW(32), .AW(32), .BW(8), .UW(1)) ia_if ();
    hci_core_intf #(.DW(32), .AW(32), .BW(8), .UW(1)) tb_if ();
    hci_core_intf #(.DW(32), .AW(32), .BW(8), .UW(1)) ib_if ();

    hci_core_outstanding_gate #(
        .AW(32), .DW(32), .UW(1), .MAX_OUTSTANDING(1), .TIMEOUT_CYCLES(8)
    ) dut_a (
        .clk_i(clk), .rst_i(rst), .target(ta_if), .initiator(ia_if),
        .outstanding_o(outst_a), .timeout_o(tmo_a)
    );

    hci_core_outstanding_gate #(
        .AW(32), .DW(32), .UW(1), .MAX_OUTSTANDING(2), .TIMEOUT_CYCLES(256)
    ) dut_b (
        .clk_i(clk), .rst_i(rst), .target(tb_if), .initiator(ib_if),
        .outstanding_o(outst_b), .timeout_o(tmo_b)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        ta_if.req = 1'b1; ta_if.add = '0; ta_if.wen = 1'b0; ta_if.data = '0;
        ta_if.be = 4'hF; ta_if.user = '0; ta_if.r_ready = 1'b1;
        ia_if.gnt = 1'b0; ia_if.r_data = '0; ia_if.r_valid = 1'b0;
        ia_if.r_user = '0; ia_if.r_opc = 1'b0;
        tb_if.req = 1'b0; tb_if.add = '0; tb_if.wen = 1'b0; tb_if.data = '0;
        tb_if.be = 4'hF; tb_if.user = '0; tb_if.r_ready = 1'b1;
        ib_if.gnt = 1'b0; ib_if.r_data = '0; ib_if.r_valid = 1'b0;
        ib_if.r_user = '0; ib_if.r_opc = 1'b0;

        // Reset held two cycles with a pending upstream request
        for (int i = 0; i < 2; i++) begin
            step();
            check("rst_ireq", ia_if.req, 0);
            check("rst_tgnt", ta_if.gnt, 1);
            check("rst_out", outst_a, 0);
            check("rst_tmo", tmo_a, 0);
        end
        rst = 1'b0; ta_if.req = 1'b0;
        step();
        check("post_rst_ireq", ia_if.req, 0);
        check("post_rst_tgnt", ta_if.gnt, 1);

        // Single read
        ta_if.req = 1'b1; ta_if.add = 32'h100; ta_if.wen = 1'b1; #1;
        check("rd_tgnt_c0", ta_if.gnt, 1);
        step(); ta_if.req = 1'b0; ia_if.gnt = 1'b1; #1;
        check("rd_ireq_c1", ia_if.req, 1);
        check("rd_iadd_c1", ia_if.add, 32'h100);
        check("rd_iwen_c1", ia_if.wen, 1);
        step(); ia_if.gnt = 1'b0; #1;
        check("rd_out_c2", outst_a, 1);
        check("rd_ireq_c2", ia_if.req, 0);
        step(); ia_if.r_valid = 1'b1; ia_if.r_data = 32'hDEADBEEF; ia_if.r_opc = 1'b1; #1;
        check("rd_out_c3", outst_a, 1);
        check("rd_rdata_c3", ta_if.r_data, 32'hDEADBEEF);
        check("rd_rvalid_c3", ta_if.r_valid, 1);
        check("rd_ropc_c3", ta_if.r_opc, 1);
        step(); ia_if.r_valid = 1'b0; ia_if.r_opc = 1'b0; #1;
        check("rd_out_c4", outst_a, 0);

        // Cap of one: A issues, B waits in the slot until A's response
        step(); ta_if.req = 1'b1; ta_if.add = 32'h200; ta_if.wen = 1'b0; ia_if.gnt = 1'b1; #1;
        check("cap_tgnt_c0", ta_if.gnt, 1);
        step(); ta_if.add = 32'h300; #1;
        check("cap_ireq_c1", ia_if.req, 1);
        check("cap_iadd_c1", ia_if.add, 32'h200);
        check("cap_tgnt_c1", ta_if.gnt, 1);
        step(); ta_if.add = 32'h400; #1;
        for (int c = 2; c <= 4; c++) begin
            if (c > 2) step();
            check("cap_ireq_hold", ia_if.req, 0);
            check("cap_iadd_hold", ia_if.add, 32'h300);
            check("cap_tgnt_hold", ta_if.gnt, 0);
            check("cap_out_hold", outst_a, 1);
        end
        step(); ia_if.r_valid = 1'b1; #1;
        check("cap_ireq_c5", ia_if.req, 0);
        check("cap_tgnt_c5", ta_if.gnt, 0);
        step(); ia_if.r_valid = 1'b0; #1;
        check("cap_ireq_c6", ia_if.req, 1);
        check("cap_iadd_c6", ia_if.add, 32'h300);
        check("cap_tgnt_c6", ta_if.gnt, 1);
        check("cap_out_c6", outst_a, 0);
        step(); ta_if.req = 1'b0; ia_if.r_valid = 1'b1; #1;
        check("cap_ireq_c7", ia_if.req, 0);
        check("cap_iadd_c7", ia_if.add, 32'h400);
        step(); ia_if.r_valid = 1'b0; #1;
        check("cap_ireq_c8", ia_if.req, 1);
        step(); ia_if.r_valid = 1'b1; #1;
        check("cap_out_c9", outst_a, 1);
        step(); ia_if.r_valid = 1'b0; ia_if.gnt = 1'b0; #1;
        check("cap_out_c10", outst_a, 0);
        check("cap_ireq_c10", ia_if.req, 0);

        // Response backpressure, then a spurious response with nothing outstanding
        step(); ta_if.req = 1'b1; ta_if.add = 32'h500; ia_if.gnt = 1'b1; #1;
        step(); ta_if.req = 1'b0; #1;
        check("bp_ireq_c1", ia_if.req, 1);
        step(); ia_if.gnt = 1'b0; ia_if.r_valid = 1'b1; ta_if.r_ready = 1'b0; #1;
        for (int c = 2; c <= 4; c++) begin
            if (c > 2) step();
            check("bp_out_stall", outst_a, 1);
            check("bp_iready_stall", ia_if.r_ready, 0);
        end
        step(); ta_if.r_ready = 1'b1; #1;
        check("bp_out_c5", outst_a, 1);
        check("bp_iready_c5", ia_if.r_ready, 1);
        step(); #1;
        check("bp_out_c6", outst_a, 0);
        step(); ia_if.r_valid = 1'b0; #1;
        check("spur_out", outst_a, 0);

        // Cap of two, then issue and done in the same cycle
        tb_if.req = 1'b1; tb_if.add = 32'h30; ib_if.gnt = 1'b1; #1;
        step(); tb_if.add = 32'h40; #1;
        check("b_tgnt_c1", tb_if.gnt, 1);
        step(); tb_if.add = 32'h50; #1;
        check("b_out_c2", outst_b, 1);
        check("b_ireq_c2", ib_if.req, 1);
        check("b_tgnt_c2", tb_if.gnt, 1);
        step(); tb_if.req = 1'b0; ib_if.r_valid = 1'b1; #1;
        check("b_out_c3", outst_b, 2);
        check("b_ireq_c3", ib_if.req, 0);
        check("b_tgnt_c3", tb_if.gnt, 0);
        step(); #1;
        check("b_out_c4", outst_b, 1);
        check("b_ireq_c4", ib_if.req, 1);
        check("b_iadd_c4", ib_if.add, 32'h50);
        step(); #1;
        check("b_simul_out_c5", outst_b, 1);
        step(); ib_if.r_valid = 1'b0; ib_if.gnt = 1'b0; #1;
        check("b_out_c6", outst_b, 0);

        // Watchdog: grant, then no response
        ta_if.req = 1'b1; ta_if.add = 32'h600; #1;
        step(); ta_if.req = 1'b0; ia_if.gnt = 1'b1; #1;
        check("wd_ireq_c0", ia_if.req, 1);
        step(); ia_if.gnt = 1'b0; #1;
        for (int c = 1; c <= 8; c++) begin
            if (c > 1) step();
            check("wd_tmo_early", tmo_a, 0);
        end
        step();
        check("wd_tmo_c9", tmo_a, EXP_TMO);
        step(); ia_if.r_valid = 1'b1; #1;
        check("wd_tmo_c10", tmo_a, EXP_TMO);
        step(); ia_if.r_valid = 1'b0; #1;
        check("wd_out_c11", outst_a, 0);
        check("wd_tmo_c11", tmo_a, EXP_TMO);
        step(); #1;
        check("wd_tmo_sticky", tmo_a, EXP_TMO);
        rst = 1'b1;
        step();
        check("wd_tmo_rst", tmo_a, 0);
        check("wd_out_rst", outst_a, 0);
        rst = 1'b0;
        step();
        check("wd_tmo_after_rst", tmo_a, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/hci_core_outstanding_gate.md
# hci_core_outstanding_gate

Request-side pipeline stage placed directly upstream of an HCI core memory-map demux. It registers incoming requests in a one-entry slot and caps the number of outstanding downstream transactions at `MAX_OUTSTANDING`, so the demux's single-region response tracking is never violated. Responses pass straight through, and an outstanding-transaction counter is exposed. An optional watchdog flags responses that never arrive.

## Interface
- `AW`, default `hci_package::DEFAULT_AW`: address width.
- `DW`, default `hci_package::DEFAULT_DW`: data width.
- `UW`, default `hci_package::DEFAULT_UW`: user width.
- `MAX_OUTSTANDING`, default 1: maximum number of granted-but-unanswered downstream transactions; must be ≥1.
- `TIMEOUT_CYCLES`, default 256: watchdog threshold; must be ≥1. Only used with `HCI_OUTSTANDING_GATE_TIMEOUT_EN`.
- `clk_i`  in  1  clock. One clock domain.
- `rst_i`  in  1  reset, synchronous, active-high.
- `target`  hci_core_intf.target  -  upstream side, fed by the core or initiator.
- `initiator`  hci_core_intf.initiator  -  downstream side, feeds the demux.
- `outstanding_o`  out  `$clog2(MAX_OUTSTANDING+1)`  current outstanding count (`cnt_q`).
- `timeout_o`  out  1  sticky watchdog flag.

## Operation
- Slot register: `slot_v_q` plus captured `add`, `wen`, `data`, `be`, `user`.
  - `target.gnt = !slot_v_q || issue`.
  - On a target handshake (`target.req && target.gnt`), the slot loads and `slot_v_q` is set to 1.
  - Otherwise, `issue` clears `slot_v_q`.
- Issue:
  - `initiator.req = slot_v_q && (cnt_q < MAX_OUTSTANDING)`.
  - `issue = initiator.req && initiator.gnt`.
  - `initiator.add/wen/data/be/user` are driven from the slot.
- Completion: `done = initiator.r_valid && initiator.r_ready`. Every issued request, read or write, yields exactly one downstream response beat.
- Counter update:
  - `cnt_d = cnt_q + issue - done`.
  - `issue` and `done` in the same cycle leave `cnt_q` unchanged.
  - `done` with `cnt_q==0` and no `issue` is spurious. It is ignored and the counter holds at 0; no underflow.
- Response path is purely combinational:
  - `target.r_valid/r_data/r_user/r_opc` = `initiator.*`.
  - `initiator.r_ready = target.r_ready`.
- Reset:
  - `slot_v_q=0` and `cnt_q=0`.
  - `timeout_o=0` and the timer is 0.
  - Slot payload registers are cleared to 0.
- Reset mid-operation: in-flight transactions are forgotten. Their later responses still pass through but are not counted (the underflow rule applies).

## Timing
- Request latency: a target handshake in cycle N makes `initiator.req` visible in cycle N+1, provided the cap allows it.
- `target.gnt` combinationally depends on `initiator.gnt` and `cnt_q`. There are no other combinational request paths.
- Full throughput (one request per cycle) is possible when `initiator.gnt=1` and the cap is not reached.
- Cap reached (`cnt_q==MAX_OUTSTANDING`):
  - `initiator.req=0`.
  - A valid slot holds its contents and `target.gnt=0`.
  - A `done` in cycle M drops `cnt_q` in M+1, and `initiator.req` may reassert in M+1.
- Response latency is 0: target response signals equal initiator response signals in the same cycle.
- `initiator.req` stays asserted, with stable payload, until granted. It is never withdrawn.
- Output values during and just after reset:
  - `initiator.req=0` and `target.gnt=1`.
  - `outstanding_o=0` and `timeout_o=0`.
  - Target response outputs follow the initiator.

## Configuration
- Macro `HCI_OUTSTANDING_GATE_TIMEOUT_EN`.
- Defined:
  - A timer `tmr_q` of width `$clog2(TIMEOUT_CYCLES+1)`.
  - `tmr_q` is 0 while `cnt_q==0` and resets to 0 on any `done`.
  - Otherwise `tmr_q` increments each cycle, saturating at `TIMEOUT_CYCLES`.
  - `timeout_o` is set the cycle `tmr_q==TIMEOUT_CYCLES` and stays set until `rst_i`.
- Undefined: no timer logic, `timeout_o` is tied to 0, and `TIMEOUT_CYCLES` is ignored.

## Test plan
- Reset: hold `rst_i`=1 for 2 cycles with `target.req`=1. Required: `initiator.req`=0, `target.gnt`=1, `outstanding_o`=0, `timeout_o`=0 throughout. The slot is empty after reset is released.
- Single read:
  - Stimulus: handshake at cycle 0 with `add`=0x100, `wen`=1; `initiator.gnt`=1 at cycle 1; `r_valid` at cycle 3 with `r_data`=0xDEADBEEF, `r_ready`=1.
  - Required: `initiator.req`=1 at cycle 1 with `add`=0x100; `outstanding_o`=1 in cycles 2–3; `target.r_data`=0xDEADBEEF at cycle 3; `outstanding_o`=0 at cycle 4.
- Cap with `MAX_OUTSTANDING`=1:
  - Stimulus: two back-to-back requests A and B; response for A completes at cycle 5.
  - Required: B is latched in the slot with `initiator.req`=0 during cycles 2–5 and `target.gnt`=0 for a third request. B issues at cycle 6.
- Simultaneous events with `MAX_OUTSTANDING`=2 and `cnt_q`=1: `issue` and `done` in the same cycle. Required: `outstanding_o` stays 1.
- Backpressure and spurious response:
  - `r_valid`=1 with `r_ready`=0 for 3 cycles: counter is unchanged, then decrements once `r_ready`=1.
  - `r_valid && r_ready` with count 0: count stays 0.
- Watchdog, with macro defined and `TIMEOUT_CYCLES`=8:
  - Stimulus: grant at cycle 0, then no response.
  - Required: `timeout_o` rises at cycle 9 and stays high after a later response; only `rst_i` clears it.
  - Without the macro: `timeout_o`=0 always.
